// File: rtl/rd_lat_pkg.sv
// Shared constants and types for the rd_latency0_to_n read-latency adapter.
package rd_lat_pkg;

  localparam int MAX_LATENCY = 8;

  typedef logic [15:0] cnt16_t;

  localparam cnt16_t CNT_MAX = 16'hFFFF;

  // Saturating increment: holds at CNT_MAX instead of wrapping to zero.
  function automatic cnt16_t sat_inc(input cnt16_t c);
    return (c == CNT_MAX) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/rd_lat_delay_line.sv
// Fixed-depth valid/data shift pipeline with synchronous flush of all valid bits.
// Optional error bit per slot when RD_LAT_UNDERFLOW_ERR_EN is defined.
module rd_lat_delay_line
  import rd_lat_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             valid_in,
`ifdef RD_LAT_UNDERFLOW_ERR_EN
  input  logic             err_in,
  output logic             err_out,
`endif
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  // Data only moves with a live valid bit, so the last stage holds its word through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_in & ~flush;
      if (valid_in & ~flush) dat_q[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1] & ~flush;
        if (vld_q[i-1] & ~flush) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_out = vld_q[DEPTH-1];
  assign data_out  = dat_q[DEPTH-1];

`ifdef RD_LAT_UNDERFLOW_ERR_EN
  logic [DEPTH-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q[0] <= err_in & ~flush;
      for (int i = 1; i < DEPTH; i++) err_q[i] <= err_q[i-1] & ~flush;
    end
  end

  assign err_out = err_q[DEPTH-1];
`endif

endmodule

// File: rtl/rd_latency0_to_n.sv
// Adapts a show-ahead (latency-0) source to a fixed LATENCY-cycle read interface.
// Optional feature macro: RD_LAT_UNDERFLOW_ERR_EN adds the out_rd_err output.
module rd_latency0_to_n
  import rd_lat_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             in_rd_en,
  input  logic             in_rd_valid,
  input  logic [WIDTH-1:0] in_rd_data,
  input  logic             out_rd_en,
  output logic             out_rd_valid,
  output logic [WIDTH-1:0] out_rd_data,
  input  logic             flush,
  output logic             underflow_sticky,
  input  logic             underflow_clr,
`ifdef RD_LAT_UNDERFLOW_ERR_EN
  output logic             out_rd_err,
`endif
  output logic [15:0]      pop_count
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $fatal(1, "rd_latency0_to_n: LATENCY=%0d outside 1..%0d", LATENCY, MAX_LATENCY);
  end
  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $fatal(1, "rd_latency0_to_n: WIDTH=%0d outside 1..1024", WIDTH);
  end

  logic   req_ok;
  logic   underflow;
  logic   pop;
  cnt16_t pop_cnt_q;
  logic   sticky_q;

  // rst_n in the strobe keeps the source untouched while reset is held.
  assign req_ok    = out_rd_en & ~flush & rst_n;
  assign pop       = req_ok & in_rd_valid;
  assign underflow = req_ok & ~in_rd_valid;
  assign in_rd_en  = pop;

  rd_lat_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (LATENCY)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .valid_in  (pop),
`ifdef RD_LAT_UNDERFLOW_ERR_EN
    .err_in    (underflow),
    .err_out   (out_rd_err),
`endif
    .data_in   (in_rd_data),
    .valid_out (out_rd_valid),
    .data_out  (out_rd_data)
  );

  // Set has priority over clear when both land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q  <= 1'b0;
      pop_cnt_q <= '0;
    end else begin
      sticky_q <= underflow | (sticky_q & ~underflow_clr);
      if (pop) pop_cnt_q <= sat_inc(pop_cnt_q);
    end
  end

  assign underflow_sticky = sticky_q;
  assign pop_count        = pop_cnt_q;

endmodule

// File: doc/rd_latency0_to_n.md
RD_LATENCY0_TO_N -- requirements
Module: rd_latency0_to_n

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, legal range 1..1024.
REQ-002 Parameter LATENCY, default 2: read latency presented downstream in cycles, legal range 1..rd_lat_pkg::MAX_LATENCY (8).
REQ-003 clk  input  1  clock; all logic is rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_rd_en  output  1  pop strobe to the latency-0 (show-ahead) source.
REQ-006 in_rd_valid  input  1  source holds a word; in_rd_data is valid in the same cycle.
REQ-007 in_rd_data  input  WIDTH  head-of-source word.
REQ-008 out_rd_en  input  1  downstream read request.
REQ-009 out_rd_valid  output  1  returned word valid; exactly LATENCY cycles after the accepted request.
REQ-010 out_rd_data  output  WIDTH  returned word.
REQ-011 flush  input  1  synchronous discard of all in-flight reads.
REQ-012 underflow_sticky  output  1  set on any request made while the source is empty.
REQ-013 underflow_clr  input  1  synchronous clear of underflow_sticky.
REQ-014 pop_count  output  16  saturating count of words popped from the source.

Function
REQ-015 in_rd_en SHALL equal out_rd_en & in_rd_valid & ~flush, combinationally.
REQ-016 A pop in cycle t SHALL capture in_rd_data in cycle t and present it on out_rd_data with out_rd_valid=1 in cycle t+LATENCY only.
REQ-017 The block SHALL accept one request per cycle; back-to-back requests SHALL return back-to-back, in order, with no bubbles.
REQ-018 A request with in_rd_valid=0 (underflow) SHALL NOT pop; its slot SHALL propagate with valid=0, so out_rd_valid=0 in cycle t+LATENCY.
REQ-019 An underflow SHALL set underflow_sticky on the next edge; if underflow_clr and an underflow occur in the same cycle, set wins.
REQ-020 When out_rd_valid=0, out_rd_data SHALL hold its previous value.
REQ-021 flush=1 SHALL clear every in-flight valid bit on the next edge, so out_rd_valid=0 for cycles t+1..t+LATENCY; a request in the flush cycle SHALL be dropped, and no pop or underflow SHALL occur.
REQ-022 flush SHALL NOT alter pop_count or underflow_sticky.
REQ-023 pop_count SHALL increment by 1 per pop, saturate at 16'hFFFF and never wrap.
REQ-024 There is no backpressure on the return path; downstream SHALL always sink out_rd_valid.

Reset
REQ-025 rst_n low SHALL asynchronously clear all pipeline valid and data registers, out_rd_valid, out_rd_data, underflow_sticky and pop_count to 0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight reads; no out_rd_valid SHALL appear from requests made before reset.
REQ-027 While rst_n is low, in_rd_en SHALL be 0.

Configuration
REQ-028 Macro RD_LAT_UNDERFLOW_ERR_EN, when defined, SHALL add output out_rd_err (1 bit), asserted in cycle t+LATENCY for an underflow request in cycle t and reset to 0.
REQ-029 Without RD_LAT_UNDERFLOW_ERR_EN, the out_rd_err port and its pipeline bit SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package rd_lat_pkg SHALL hold MAX_LATENCY=8, the typedef cnt16_t (16-bit counter) and the constant CNT_MAX.
REQ-031 The delay path SHALL be one sub-module, rd_lat_delay_line (parameters WIDTH and DEPTH; ports valid/err/data in, out and a flush input), instantiated once.
REQ-032 Parameter legality SHALL be checked at elaboration, with a fatal error for LATENCY outside 1..MAX_LATENCY.

Verification
REQ-033 LATENCY=2, source holds A5A5_0001: out_rd_en pulse at cycle 10 -> in_rd_en=1 at cycle 10; out_rd_valid=1 with data 0xA5A50001 at cycle 12 only; pop_count=1.
REQ-034 LATENCY=3, four consecutive requests with data 1,2,3,4 -> valid in cycles t+3..t+6, carrying 1,2,3,4 in order, with no gaps.
REQ-035 Source empty, request at cycle 5 -> in_rd_en=0; underflow_sticky=1 from cycle 6; out_rd_valid=0 at cycle 5+LATENCY; with the macro defined, out_rd_err=1 at cycle 5+LATENCY.
REQ-036 LATENCY=4, requests at cycles 0..2 and flush at cycle 3 (with a request) -> no out_rd_valid in cycles 4..7; pop_count=3.
REQ-037 pop_count preloaded near saturation by 65540 pops -> pop_count reads 0xFFFF and stays there.
REQ-038 rst_n asserted at cycle 1 after a request at cycle 0, released at cycle 3 (LATENCY=2) -> out_rd_valid stays 0, and all outputs are 0 during reset.
